// File: rtl/aes_ctrl_multi.sv
// -----------------------------------------------------------------------------
// aes_ctrl_multi
//   Top-level sequencer for the AES accelerator. It sits between the AHB-lite
//   slave, the key generator and the AES round core. One accepted start either
//   loads a key, or runs a programmed number of 128-bit blocks through the
//   core. Each block runs in this order: prefetch dwell, read, wait for the
//   core, write.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   start             one-cycle request; only looked at in IDLE
//   change_key        qualifies start: 1 = key load, 0 = data run
//   decrypt           qualifies start: 1 = decrypt, 0 = encrypt
//   num_blocks        qualifies start: number of blocks in the data run
//   chg_key_done      key generator has stored the key
//   enc_done          AES core finished the current block
//   abort             cancel the current operation (ignored in IDLE)
//   change_key_start  high for the whole key load
//   aes_enable        core enable for WAIT_START/READ/WAIT_AES/WRITE
//   aes_decrypt       mode latched at the last accepted data start
//   ahb_mode          0 = read SRAM, 1 = write SRAM (WRITE only)
//   ahb_shift_en      one-cycle shift strobe in INIT_READ, READ, WRITE
//   busy              any state other than IDLE
//   done              one-cycle pulse on normal completion
//   err               sticky error from abort or key timeout; cleared by start
//   blocks_done       blocks written in the current run
// -----------------------------------------------------------------------------
module aes_ctrl_multi #(
  parameter int WAIT_CYCLES = 10,
  parameter int WAIT_W      = 4,
  parameter int BLK_W       = 16,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             change_key,
  input  logic             decrypt,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             chg_key_done,
  input  logic             enc_done,
  input  logic             abort,
  output logic             change_key_start,
  output logic             aes_enable,
  output logic             aes_decrypt,
  output logic             ahb_mode,
  output logic             ahb_shift_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [BLK_W-1:0] blocks_done
);

  localparam int KEY_W = $clog2(KEY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHNG_KEY   = 3'd1,
    INIT_READ  = 3'd2,
    INIT_WAIT  = 3'd3,
    WAIT_START = 3'd4,
    READ       = 3'd5,
    WAIT_AES   = 3'd6,
    WRITE      = 3'd7
  } state_t;

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [KEY_W-1:0]   key_cnt;
  logic [BLK_W-1:0]   blk_cnt;
  logic [BLK_W-1:0]   num_lat;
  logic               dec_lat;
  logic               done_q;
  logic               err_q;

  logic               start_ok;
  logic               data_start;
  logic               wait_exp;
  logic               key_exp;
  logic               dwell_state;
  logic               abort_ok;
  logic [BLK_W-1:0]   blk_inc;
  logic               last_blk;

  assign start_ok    = (state == IDLE) && start;
  assign data_start  = start_ok && !change_key;
  assign abort_ok    = (state != IDLE) && abort;
  assign dwell_state = (state == INIT_WAIT) || (state == WAIT_START);
  // Counters start at 0 on entry, so the last cycle in state is count N-1.
  assign wait_exp    = (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
  assign key_exp     = (key_cnt == KEY_W'(KEY_TIMEOUT - 1));
  assign blk_inc     = blk_cnt + BLK_W'(1);
  assign last_blk    = (blk_inc == num_lat);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    if (abort_ok) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && change_key)             state_nxt = CHNG_KEY;
          else if (start && num_blocks != '0)  state_nxt = INIT_READ;
        end
        // A key done arriving on the timeout cycle still counts as success;
        // the error flag logic below makes that distinction.
        CHNG_KEY:   if (chg_key_done || key_exp) state_nxt = IDLE;
        INIT_READ:  state_nxt = INIT_WAIT;
        INIT_WAIT:  if (wait_exp) state_nxt = WAIT_START;
        WAIT_START: if (wait_exp) state_nxt = READ;
        READ:       state_nxt = WAIT_AES;
        WAIT_AES:   if (enc_done) state_nxt = WRITE;
        WRITE:      state_nxt = last_blk ? IDLE : WAIT_START;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    change_key_start = 1'b0;
    aes_enable       = 1'b0;
    ahb_mode         = 1'b0;
    ahb_shift_en     = 1'b0;
    busy             = (state != IDLE);
    case (state)
      CHNG_KEY:   change_key_start = 1'b1;
      INIT_READ:  ahb_shift_en     = 1'b1;
      WAIT_START: aes_enable       = 1'b1;
      READ: begin
        aes_enable   = 1'b1;
        ahb_shift_en = 1'b1;
      end
      WAIT_AES:   aes_enable = 1'b1;
      WRITE: begin
        aes_enable   = 1'b1;
        ahb_shift_en = 1'b1;
        ahb_mode     = 1'b1;
      end
      default: ;
    endcase
  end

  // Dwell and key-timeout counters, run-state registers, done/err flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      key_cnt  <= '0;
      blk_cnt  <= '0;
      num_lat  <= '0;
      dec_lat  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // Count only while staying in a dwell state; any state change clears.
      if (dwell_state && state_nxt == state) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                   wait_cnt <= '0;

      if (state == CHNG_KEY && state_nxt == state) key_cnt <= key_cnt + KEY_W'(1);
      else                                         key_cnt <= '0;

      if (data_start) begin
        blk_cnt <= '0;
        num_lat <= num_blocks;
        dec_lat <= decrypt;
      end else if (state == WRITE && !abort_ok) begin
        blk_cnt <= blk_inc;
      end

      done_q <= (data_start && num_blocks == '0)
             || (state == CHNG_KEY && !abort_ok && chg_key_done)
             || (state == WRITE && !abort_ok && last_blk);

      if (start_ok)
        err_q <= 1'b0;
      else if (abort_ok || (state == CHNG_KEY && key_exp && !chg_key_done))
        err_q <= 1'b1;
    end
  end

  assign aes_decrypt = dec_lat;
  assign done        = done_q;
  assign err         = err_q;
  assign blocks_done = blk_cnt;

endmodule

// File: tb/tb_aes_ctrl_multi.sv
// -----------------------------------------------------------------------------
// tb_aes_ctrl_multi
//   Directed bench for aes_ctrl_multi with default parameters
//   (WAIT_CYCLES=10, BLK_W=16, KEY_TIMEOUT=64).
// -----------------------------------------------------------------------------
module tb_aes_ctrl_multi;

  localparam int BLK_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, change_key, decrypt, chg_key_done, enc_done, abort;
  logic [BLK_W-1:0] num_blocks;
  logic             change_key_start, aes_enable, aes_decrypt, ahb_mode;
  logic             ahb_shift_en, busy, done, err;
  logic [BLK_W-1:0] blocks_done;

  int checks   = 0;
  int failures = 0;

  aes_ctrl_multi #(
    .WAIT_CYCLES(10), .WAIT_W(4), .BLK_W(BLK_W), .KEY_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .change_key(change_key),
    .decrypt(decrypt), .num_blocks(num_blocks), .chg_key_done(chg_key_done),
    .enc_done(enc_done), .abort(abort), .change_key_start(change_key_start),
    .aes_enable(aes_enable), .aes_decrypt(aes_decrypt), .ahb_mode(ahb_mode),
    .ahb_shift_en(ahb_shift_en), .busy(busy), .done(done), .err(err),
    .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the next shift strobe; n is the number of edges taken.
  task automatic wait_shift(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ahb_shift_en && n < 200);
  endtask

  task automatic issue(input logic ck, input logic dec, input logic [BLK_W-1:0] nb);
    start = 1'b1; change_key = ck; decrypt = dec; num_blocks = nb;
    tick();
    start = 1'b0; change_key = 1'b0; decrypt = 1'b0; num_blocks = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({change_key_start, aes_enable, aes_decrypt, ahb_mode, ahb_shift_en,
         busy, done, err, blocks_done} !== 24'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0d en=%0d err=%0d bd=%0d exp all 0",
               busy, aes_enable, err, blocks_done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%0d exp 0", busy); end
  endtask

  task automatic test_single_enc();
    int n;
    issue(1'b0, 1'b0, 16'd1);
    checks++;
    if (ahb_shift_en !== 1'b1 || ahb_mode !== 1'b0 || aes_enable !== 1'b0) begin
      failures++;
      $display("FAIL single_init_read shift=%0d mode=%0d en=%0d exp 1/0/0",
               ahb_shift_en, ahb_mode, aes_enable);
    end
    wait_shift(n);
    checks++;
    if (n + 1 !== 22) begin failures++; $display("FAIL single_read_cycle got=%0d exp=22", n + 1); end
    checks++;
    if (aes_enable !== 1'b1 || ahb_mode !== 1'b0) begin
      failures++; $display("FAIL single_read_outs en=%0d mode=%0d exp 1/0", aes_enable, ahb_mode);
    end
    repeat (4) tick();
    checks++;
    if (ahb_shift_en !== 1'b0 || aes_enable !== 1'b1) begin
      failures++; $display("FAIL single_wait_aes shift=%0d en=%0d exp 0/1", ahb_shift_en, aes_enable);
    end
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    checks++;
    if (ahb_shift_en !== 1'b1 || ahb_mode !== 1'b1 || blocks_done !== 16'd0) begin
      failures++;
      $display("FAIL single_write shift=%0d mode=%0d bd=%0d exp 1/1/0",
               ahb_shift_en, ahb_mode, blocks_done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || blocks_done !== 16'd1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_done done=%0d bd=%0d busy=%0d err=%0d exp 1/1/0/0",
               done, blocks_done, busy, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || blocks_done !== 16'd1) begin
      failures++; $display("FAIL single_hold done=%0d bd=%0d exp 0/1", done, blocks_done);
    end
  endtask

  // Also covers enc_done arriving in the READ cycle of block 1.
  task automatic test_multi_dec();
    int n;
    issue(1'b0, 1'b1, 16'd3);
    wait_shift(n);
    checks++;
    if (n !== 21) begin failures++; $display("FAIL multi_first_read got=%0d exp=21", n); end
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    checks++;
    if (ahb_shift_en !== 1'b0 || aes_enable !== 1'b1) begin
      failures++; $display("FAIL enc_in_read_ignored shift=%0d en=%0d exp 0/1", ahb_shift_en, aes_enable);
    end
    for (int b = 1; b <= 3; b++) begin
      if (b > 1) begin
        wait_shift(n);
        checks++;
        if (n !== 11) begin failures++; $display("FAIL multi_gap blk=%0d got=%0d exp=11", b, n); end
        tick();
      end
      enc_done = 1'b1;
      tick();
      enc_done = 1'b0;
      checks++;
      if (ahb_mode !== 1'b1 || ahb_shift_en !== 1'b1 || aes_decrypt !== 1'b1 ||
          blocks_done !== 16'(b - 1)) begin
        failures++;
        $display("FAIL multi_write blk=%0d mode=%0d shift=%0d dec=%0d bd=%0d exp 1/1/1/%0d",
                 b, ahb_mode, ahb_shift_en, aes_decrypt, blocks_done, b - 1);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || blocks_done !== 16'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL multi_done done=%0d bd=%0d busy=%0d exp 1/3/0", done, blocks_done, busy);
    end
  endtask

  task automatic test_key_load();
    int hi;
    int n;
    logic saw_done;
    issue(1'b1, 1'b0, 16'd0);
    hi = 0;
    for (int i = 1; i <= 20; i++) begin
      if (change_key_start) hi++;
      if (i == 20) chg_key_done = 1'b1;
      tick();
    end
    chg_key_done = 1'b0;
    checks++;
    if (hi !== 20 || done !== 1'b1 || err !== 1'b0 || change_key_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL key_load hi=%0d done=%0d err=%0d cks=%0d busy=%0d exp 20/1/0/0/0",
               hi, done, err, change_key_start, busy);
    end
    checks++;
    if (aes_decrypt !== 1'b1) begin failures++; $display("FAIL key_keeps_mode dec=%0d exp 1", aes_decrypt); end
    // Timeout path
    issue(1'b1, 1'b0, 16'd0);
    n = 1;
    saw_done = 1'b0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (n !== 65 || err !== 1'b1 || saw_done !== 1'b0) begin
      failures++;
      $display("FAIL key_timeout exit_cycle=%0d err=%0d done_seen=%0d exp 65/1/0", n, err, saw_done);
    end
    // Key done on the expiry cycle counts as success
    issue(1'b1, 1'b0, 16'd0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) chg_key_done = 1'b1;
      tick();
    end
    chg_key_done = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL key_done_at_expiry done=%0d err=%0d busy=%0d exp 1/0/0", done, err, busy);
    end
  endtask

  task automatic test_abort();
    int n;
    issue(1'b0, 1'b0, 16'd4);
    wait_shift(n);
    tick();
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    wait_shift(n);
    tick();
    checks++;
    if (aes_enable !== 1'b1 || ahb_shift_en !== 1'b0) begin
      failures++; $display("FAIL abort_setup en=%0d shift=%0d exp 1/0", aes_enable, ahb_shift_en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || blocks_done !== 16'd1 || done !== 1'b0 || aes_enable !== 1'b0) begin
      failures++;
      $display("FAIL abort_wait_aes busy=%0d err=%0d bd=%0d done=%0d en=%0d exp 0/1/1/0/0",
               busy, err, blocks_done, done, aes_enable);
    end
    // Zero-block start: clears err, immediate done, no shift
    issue(1'b0, 1'b0, 16'd0);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || ahb_shift_en !== 1'b0 || blocks_done !== 16'd0) begin
      failures++;
      $display("FAIL zero_blocks done=%0d err=%0d busy=%0d shift=%0d bd=%0d exp 1/0/0/0/0",
               done, err, busy, ahb_shift_en, blocks_done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL zero_blocks_pulse done=%0d exp 0", done); end
  endtask

  task automatic test_busy_start_and_abort_race();
    int n;
    issue(1'b0, 1'b0, 16'd1);
    tick(); tick();
    issue(1'b1, 1'b0, 16'd5);
    checks++;
    if (change_key_start !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_while_busy cks=%0d busy=%0d exp 0/1", change_key_start, busy);
    end
    wait_shift(n);
    checks++;
    if (n !== 18) begin failures++; $display("FAIL busy_start_read got=%0d exp=18", n); end
    tick();
    enc_done = 1'b1;
    abort = 1'b1;
    tick();
    enc_done = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || done !== 1'b0 || ahb_mode !== 1'b0 || blocks_done !== 16'd0) begin
      failures++;
      $display("FAIL abort_beats_enc busy=%0d err=%0d done=%0d mode=%0d bd=%0d exp 0/1/0/0/0",
               busy, err, done, ahb_mode, blocks_done);
    end
  endtask

  task automatic test_async_reset();
    issue(1'b0, 1'b1, 16'd2);
    repeat (14) tick();
    checks++;
    if (aes_enable !== 1'b1 || ahb_shift_en !== 1'b0 || aes_decrypt !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup en=%0d shift=%0d dec=%0d exp 1/0/1", aes_enable, ahb_shift_en, aes_decrypt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({change_key_start, aes_enable, aes_decrypt, ahb_mode, ahb_shift_en,
         busy, done, err, blocks_done} !== 24'd0) begin
      failures++;
      $display("FAIL async_reset busy=%0d en=%0d dec=%0d err=%0d exp all 0",
               busy, aes_enable, aes_decrypt, err);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL after_reset busy=%0d done=%0d exp 0/0", busy, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; change_key = 1'b0; decrypt = 1'b0;
    num_blocks = '0; chg_key_done = 1'b0; enc_done = 1'b0; abort = 1'b0;
    test_reset();
    test_single_enc();
    test_multi_dec();
    test_key_load();
    test_abort();
    test_busy_start_and_abort_race();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_ctrl_multi.md
Name: aes_ctrl_multi

Overview:
- Second-generation top-level sequencer for the AES accelerator.
- Sits between the AHB-lite slave interface, the key generator, and the AES round core.
- Runs a programmed number of 128-bit blocks per start (no external last-round strobe), with:
  - encrypt/decrypt mode;
  - parametrised prefetch wait;
  - key-change timeout;
  - abort;
  - status outputs.

Parameters:
WAIT_CYCLES, 10, cycles spent in each INIT_WAIT / WAIT_START dwell (>=1)
WAIT_W, 4, width of the dwell counter; must hold WAIT_CYCLES
BLK_W, 16, width of block-count request and progress counter
KEY_TIMEOUT, 64, max cycles in CHNG_KEY before error (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request from AHB interface; sampled only in IDLE
change_key  in  1  with start: 1 = key load, 0 = data run
decrypt  in  1  with start: 1 = decrypt, 0 = encrypt; latched at accepted start
num_blocks  in  BLK_W  with start: block count; latched at accepted start
chg_key_done  in  1  key generator finished storing the key
enc_done  in  1  AES core finished the current block
abort  in  1  cancel the current operation
change_key_start  out  1  high throughout CHNG_KEY
aes_enable  out  1  high in WAIT_START, READ, WAIT_AES, WRITE
aes_decrypt  out  1  latched mode; stable for the whole run
ahb_mode  out  1  0 = read from SRAM, 1 = write to SRAM; 1 only in WRITE
ahb_shift_en  out  1  one-cycle shift strobe in INIT_READ, READ, WRITE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion of a data run or key load
err  out  1  sticky; cleared by the next accepted start
blocks_done  out  BLK_W  blocks written in the current run

Behaviour:
- Reset state: IDLE. All outputs 0; dwell counter, key-timeout counter, block counter, and latched mode/count all cleared.
- Start acceptance:
  - start is accepted only in IDLE; ignored elsewhere.
  - Accepted start with change_key=1 → CHNG_KEY.
  - Accepted start with change_key=0 and num_blocks≠0 → INIT_READ.
  - Accepted start with change_key=0 and num_blocks=0 → stays IDLE, done pulses the next cycle, err stays 0.
- CHNG_KEY:
  - chg_key_done → IDLE with a done pulse.
  - Timeout: KEY_TIMEOUT cycles in state without chg_key_done → IDLE, err=1, no done pulse.
  - Timeout counter clears on entry.
- INIT_READ (1 cycle): ahb_shift_en=1, ahb_mode=0 → INIT_WAIT.
- INIT_WAIT: dwell counter cleared on entry; exits to WAIT_START after exactly WAIT_CYCLES cycles in state.
- WAIT_START: same dwell rule → READ.
- READ (1 cycle): ahb_shift_en=1, ahb_mode=0 → WAIT_AES.
- WAIT_AES: holds until enc_done.
  - enc_done → WRITE.
  - enc_done asserted in the READ cycle is ignored; only WAIT_AES samples it.
- WRITE (1 cycle): ahb_shift_en=1, ahb_mode=1; blocks_done increments.
  - If the incremented value equals the latched count → IDLE with a done pulse.
  - Otherwise → WAIT_START.
- Latency:
  - Accepted start to first READ: 1 + 2·WAIT_CYCLES + 1 cycles.
  - Per additional block: WAIT_CYCLES + 1 + (WAIT_AES dwell) + 1.
- blocks_done:
  - Holds its value in IDLE after completion.
  - Cleared on an accepted data start.
  - Wraps naturally at 2^BLK_W (cannot occur for legal counts).
- abort:
  - Has priority over every other transition in any non-IDLE state.
  - Next state IDLE, err=1, no done pulse, strobes deasserted the following cycle.
  - Ignored in IDLE.
- Simultaneous events:
  - abort beats chg_key_done, enc_done, and timeout.
  - chg_key_done in the same cycle as timeout expiry counts as success.
- aes_decrypt: latched at an accepted data start; held until the next accepted data start. Key loads do not change it.
- Reset mid-operation: asserting rst in any state forces IDLE and reset values asynchronously. No done pulse and no err.
- Outputs are Moore-decoded from state, except done, which is registered.

Test Plan:
- Single-block encrypt, WAIT_CYCLES=10:
  - start, change_key=0, decrypt=0, num_blocks=1.
  - ahb_shift_en at cycle 1 (INIT_READ) and cycle 22 (READ).
  - enc_done 5 cycles later → WRITE with ahb_mode=1, done pulse, blocks_done=1, busy low.
- Three-block decrypt:
  - num_blocks=3, decrypt=1.
  - aes_decrypt=1 throughout; exactly 3 WRITE strobes.
  - Each post-WRITE gap to READ is 10 cycles; done after the third WRITE.
- Key load:
  - start, change_key=1; chg_key_done after 20 cycles → change_key_start high for 20 cycles, then done, err=0.
  - Repeat with no chg_key_done → IDLE after 64 cycles, err=1, no done.
- Abort in WAIT_AES on block 2 of 4:
  - IDLE next cycle, err=1, blocks_done=1, no done.
  - A new start clears err.
- Boundaries:
  - num_blocks=0 → immediate done, no ahb_shift_en.
  - start asserted while busy → ignored.
  - enc_done during READ → ignored.
  - abort together with enc_done → abort wins.
- Async reset during WAIT_START → all outputs 0 immediately, state IDLE.
